shape_op_engine: RTL and testbench



---
 rtl/shape_pkg.sv | 38 +++
 rtl/shape_op_engine_if.sv | 28 ++
 rtl/shape_mul_seq.sv | 67 ++++++
 rtl/shape_op_engine.sv | 167 ++++++++++++++++
 tb/tb_shape_op_engine.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/shape_pkg.sv
// Shared shape/operation encodings and the legality rules used by both the
// control register block and the execution engine.
package shape_pkg;

    typedef enum logic [1:0] {
        SQUARE    = 2'b01,
        RECTANGLE = 2'b10
    } shape_e;

    localparam logic [4:0] OP_NOP          = 5'b00_000;
    localparam logic [4:0] OP_PERIM        = 5'b00_001;
    localparam logic [4:0] OP_SQ_AREA      = 5'b01_000;
    localparam logic [4:0] OP_RECT_AREA    = 5'b10_000;
    localparam logic [4:0] OP_RECT_DIAG_SQ = 5'b10_001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL1,
        ST_MUL2,
        ST_DONE
    } state_e;

    function automatic logic is_legal_shape(input logic [1:0] shape);
        return (shape == SQUARE) || (shape == RECTANGLE);
    endfunction

    function automatic logic is_legal_operation(input logic [4:0] op);
        return (op == OP_NOP) || (op == OP_PERIM) || (op == OP_SQ_AREA) ||
               (op == OP_RECT_AREA) || (op == OP_RECT_DIAG_SQ);
    endfunction

    // op[4:3] names the shape an operation needs; 00 means shape-agnostic.
    function automatic logic is_legal_combination(input logic [1:0] shape, input logic [4:0] op);
        return is_legal_shape(shape) && is_legal_operation(op) &&
               ((op[4:3] == 2'b00) || (op[4:3] == shape));
    endfunction

endpackage

// File: rtl/shape_op_engine_if.sv
// Config, operand and result handshake bundle between the engine and its
// producer/consumer.
interface shape_op_engine_if #(
    parameter int DATA_W = 16
);
    logic [1:0]          cfg_shape;
    logic [4:0]          cfg_operation;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_a;
    logic [DATA_W-1:0]   in_b;
    logic                out_valid;
    logic                out_ready;
    logic [2*DATA_W-1:0] out_result;
    logic                out_ovf;
    logic                out_err;
    logic                busy;

    modport master (
        output cfg_shape, cfg_operation, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_err, busy
    );

    modport slave (
        input  cfg_shape, cfg_operation, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_err, busy
    );
endinterface

// File: rtl/shape_mul_seq.sv
// Radix-2 shift-add multiplier with a fixed DATA_W-cycle run; product is
// valid in the cycle done is high.
module shape_mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   multiplicand,
    input  logic [DATA_W-1:0]   multiplier,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [RES_W-1:0]  acc_q, acc_d;
    logic [RES_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [RES_W-1:0]  acc_step;

    // Exposing the in-flight accumulation lets a restart on the done cycle
    // coexist with the caller capturing the finished product.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done     = run_q && (cnt_q == CNT_W'(1));
    assign product  = acc_step;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, multiplicand};
            mplier_d = multiplier;
            cnt_d    = CNT_W'(DATA_W);
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            run_d    = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/shape_op_engine.sv
// Shape execution stage: snapshots config and operands on accept, computes
// perimeter/area/diagonal-squared and returns it on a valid/ready output.
module shape_op_engine
    import shape_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    shape_op_engine_if.slave   bus
);
    localparam int RES_W = 2 * DATA_W;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        shape_q, shape_d;
    logic [4:0]        op_q, op_d;
    logic              err_q, err_d;
    logic [RES_W-1:0]  p1_q, p1_d, p2_q, p2_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [RES_W-1:0]  out_result_q, out_result_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_err_q, out_err_d;

    logic              accept, cfg_legal, cfg_mul;
    logic              mul_start, mul_done;
    logic [DATA_W-1:0] mul_a, mul_b;
    logic [RES_W-1:0]  mul_product;
    logic [DATA_W:0]   ab_sum;
    logic [RES_W:0]    diag_sum;
    logic [RES_W-1:0]  perim;

    assign accept    = bus.in_valid && in_ready_q;
    assign cfg_legal = is_legal_combination(bus.cfg_shape, bus.cfg_operation);
    assign cfg_mul   = cfg_legal && ((bus.cfg_operation == OP_SQ_AREA) ||
                                     (bus.cfg_operation == OP_RECT_AREA) ||
                                     (bus.cfg_operation == OP_RECT_DIAG_SQ));

    // First multiply starts straight off the accepted operands; the second
    // (b*b for the diagonal) restarts from the snapshot on MUL1's done cycle.
    assign mul_start = (state_q == ST_IDLE && accept && cfg_mul) ||
                       (state_q == ST_MUL1 && mul_done && op_q == OP_RECT_DIAG_SQ);
    assign mul_a     = (state_q == ST_IDLE) ? bus.in_a : b_q;
    assign mul_b     = (state_q == ST_IDLE && bus.cfg_operation == OP_RECT_AREA) ? bus.in_b : mul_a;

    shape_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (mul_a),
        .multiplier   (mul_b),
        .done         (mul_done),
        .product      (mul_product)
    );

    assign ab_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diag_sum = {1'b0, p1_q} + {1'b0, p2_q};
    assign perim    = (shape_q == RECTANGLE) ? {{(RES_W-DATA_W-2){1'b0}}, ab_sum, 1'b0}
                                             : {{(RES_W-DATA_W-2){1'b0}}, a_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        shape_d      = shape_q;
        op_d         = op_q;
        err_d        = err_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        out_err_d    = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    shape_d = bus.cfg_shape;
                    op_d    = bus.cfg_operation;
                    err_d   = !cfg_legal;
                    state_d = cfg_mul ? ST_MUL1 : ST_DONE;
                end
            end
            ST_MUL1: begin
                if (mul_done) begin
                    p1_d    = mul_product;
                    state_d = (op_q == OP_RECT_DIAG_SQ) ? ST_MUL2 : ST_DONE;
                end
            end
            ST_MUL2: begin
                if (mul_done) begin
                    p2_d    = mul_product;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_err_d    = err_q;
                    out_ovf_d    = 1'b0;
                    out_result_d = '0;
                    if (!err_q) begin
                        case (op_q)
                            OP_PERIM:                 out_result_d = perim;
                            OP_SQ_AREA, OP_RECT_AREA: out_result_d = p1_q;
                            OP_RECT_DIAG_SQ: begin
                                out_result_d = diag_sum[RES_W-1:0];
                                out_ovf_d    = diag_sum[RES_W];
                            end
                            default: ;
                        endcase
                    end
                end else if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    out_result_d = '0;
                    out_ovf_d    = 1'b0;
                    out_err_d    = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            shape_q      <= '0;
            op_q         <= '0;
            err_q        <= 1'b0;
            p1_q         <= '0;
            p2_q         <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shape_q      <= shape_d;
            op_q         <= op_d;
            err_q        <= err_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            out_err_q    <= out_err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_err    = out_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shape_op_engine.sv
// Scoreboard bench for shape_op_engine: directed jobs push hand-computed
// results, a negedge monitor checks latency and values at the output.
module tb_shape_op_engine;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    shape_op_engine_if #(.DATA_W(16)) bus();

    shape_op_engine #(.DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    bit   seen = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: first valid cycle checks latency and values, handshake re-checks and pops.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    if (!seen) chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                    seen = 1'b1;
                end else if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                    chk("result", 64'(bus.out_result), 64'(sbq[0].res));
                    chk("ovf", 64'(bus.out_ovf), 64'(sbq[0].ovf));
                    chk("err", 64'(bus.out_err), 64'(sbq[0].err));
                end
                if (bus.out_ready) begin
                    if (sbq.size() > 0) begin
                        chk("result_at_handshake", 64'({bus.out_ovf, bus.out_err, bus.out_result}),
                            64'({sbq[0].ovf, sbq[0].err, sbq[0].res}));
                        $display("txn: result=%08h ovf=%0d err=%0d latency=%0d",
                                 bus.out_result, bus.out_ovf, bus.out_err, sbq[0].lat);
                        void'(sbq.pop_front());
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        chk("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic issue(input logic [1:0] sh, input logic [4:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] er, input logic eo, input logic ee,
                         input int lat, input bit push);
        exp_t e;
        wait_ready();
        bus.cfg_shape     = sh;
        bus.cfg_operation = op;
        bus.in_a          = a;
        bus.in_b          = b;
        bus.in_valid      = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'hA5A5;
        bus.in_b     = 16'h5A5A;
        if (push) begin
            e.res = er; e.ovf = eo; e.err = ee; e.lat = lat; e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 64'(sbq.size()), 64'd0);
        chk("post_hs_valid", 64'(bus.out_valid), 64'd0);
        chk("post_hs_clear", 64'({bus.out_result, bus.out_ovf, bus.out_err}), 64'd0);
    endtask

    task automatic job(input logic [1:0] sh, input logic [4:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] er, input logic eo, input logic ee, input int lat);
        issue(sh, op, a, b, er, eo, ee, lat, 1'b1);
        drain();
    endtask

    initial begin
        int n;
        bit rose;
        rst_n             = 1'b0;
        bus.out_ready     = 1'b1;
        bus.in_valid      = 1'b0;
        bus.cfg_shape     = 2'b00;
        bus.cfg_operation = 5'b0;
        bus.in_a          = '0;
        bus.in_b          = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outputs", 64'({bus.out_result, bus.out_ovf, bus.out_err}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        job(2'b01, 5'b01_000, 16'd300,    16'd0,    32'd90000,      1'b0, 1'b0, 17);
        job(2'b10, 5'b10_001, 16'd3,      16'd4,    32'd25,         1'b0, 1'b0, 33);
        job(2'b10, 5'b10_001, 16'hFFFF,   16'hFFFF, 32'hFFFC_0002,  1'b1, 1'b0, 33);
        job(2'b10, 5'b00_001, 16'd5,      16'd7,    32'd24,         1'b0, 1'b0, 1);
        job(2'b01, 5'b00_001, 16'd5,      16'd999,  32'd20,         1'b0, 1'b0, 1);
        job(2'b10, 5'b01_000, 16'd9,      16'd9,    32'd0,          1'b0, 1'b1, 1);
        job(2'b11, 5'b00_000, 16'd9,      16'd9,    32'd0,          1'b0, 1'b1, 1);
        job(2'b10, 5'b00_000, 16'd9,      16'd3,    32'd0,          1'b0, 1'b0, 1);
        job(2'b10, 5'b10_000, 16'd0,      16'd1234, 32'd0,          1'b0, 1'b0, 17);
        job(2'b01, 5'b10_011, 16'd4,      16'd4,    32'd0,          1'b0, 1'b1, 1);

        // Backpressure with a config change mid-job.
        bus.out_ready = 1'b0;
        issue(2'b10, 5'b10_000, 16'd6, 16'd7, 32'd42, 1'b0, 1'b0, 17, 1'b1);
        bus.cfg_shape     = 2'b01;
        bus.cfg_operation = 5'b01_000;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.busy, bus.out_ovf, bus.out_err, bus.out_result}),
                64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd42}));
        end
        bus.out_ready = 1'b1;
        drain();
        job(2'b01, 5'b01_000, 16'd6, 16'd0, 32'd36, 1'b0, 1'b0, 17);

        // Reset in the middle of MUL1: the job must vanish.
        issue(2'b10, 5'b10_000, 16'd100, 16'd200, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) rose = 1'b1;
        end
        chk("post_rst_quiet", 64'(rose), 64'd0);
        job(2'b01, 5'b01_000, 16'd12, 16'd0, 32'd144, 1'b0, 1'b0, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
